clm_lift_encoder: RTL and testbench

CLM_LIFT_ENCODER -- requirements
Module: clm_lift_encoder

---
 rtl/clm_lift_encoder.sv | 113 +++++++++++
 tb/tb_clm_lift_encoder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clm_lift_encoder.sv
// Lifts each of the 16 bytes of an AES state into GF(2)[x] by adding a
// random multiple of a base polynomial, one element per clock.
module clm_lift_encoder #(
    parameter int d = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        drdy_i,
    input  logic [8:0]                  P,
    input  logic [3:0][3:0][7:0]        pt,
    input  logic [d-1:0]                rnd,
    output logic [3:0][3:0][d+7:0]      out,
    output logic                        busy,
    output logic                        drdy_o
);

    // Polynomials are stored with the highest power in the leftmost bit,
    // so each vector's numeric value is the polynomial evaluated at x=2.
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                     state_reg, state_next;
    logic [3:0]                 cnt_reg;
    logic [3:0][3:0][7:0]       pt_reg;
    logic [8:0]                 p_reg;
    logic [3:0][3:0][d+7:0]     out_reg;
    logic [d+7:0]               prod;
    logic [7:0]                 cur_byte;
    logic [d+7:0]               elem_next;
    logic                       accept;
    logic                       write_en;

    assign accept   = (state_reg == S_IDLE) && drdy_i;
    assign write_en = (state_reg == S_BUSY);

    // Carry-less product of the live mask with the latched base polynomial.
    always_comb begin
        prod = '0;
        for (int i = 0; i < d; i++) begin
            if (rnd[i]) begin
                prod = prod ^ ((d+8)'(p_reg) << i);
            end
        end
    end

    assign cur_byte  = pt_reg[cnt_reg[3:2]][cnt_reg[1:0]];
    assign elem_next = prod ^ (d+8)'(cur_byte);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        drdy_o     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (drdy_i) begin
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (cnt_reg == 4'd15) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                drdy_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            pt_reg  <= '0;
            p_reg   <= '0;
        end else if (accept) begin
            cnt_reg <= '0;
            pt_reg  <= pt;
            p_reg   <= P;
        end else if (write_en && (cnt_reg != 4'd15)) begin
            cnt_reg <= cnt_reg + 4'd1;
        end
    end

    // One register per element; only the element selected by the counter moves.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_elem
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_reg[gi/4][gi%4] <= '0;
                end else if (write_en && (cnt_reg == 4'(gi))) begin
                    out_reg[gi/4][gi%4] <= elem_next;
                end
            end
        end
    endgenerate

    assign out = out_reg;

endmodule

// File: tb/tb_clm_lift_encoder.sv
// Self-checking bench for clm_lift_encoder: scoreboarded conversions,
// ignored strobes, mid-operation reset and back-to-back strobes.
module tb_clm_lift_encoder;

    localparam int D = 7;

    typedef logic [3:0][3:0][7:0]   pt_t;
    typedef logic [3:0][3:0][D+7:0] ov_t;
    typedef logic [15:0][D-1:0]     rv_t;

    logic           clk;
    logic           rst;
    logic           drdy_i;
    logic [8:0]     P;
    pt_t            pt;
    logic [D-1:0]   rnd;
    ov_t            out_v;
    logic           busy;
    logic           drdy_o;

    int  errors = 0;
    int  checks = 0;
    ov_t sb[$];
    ov_t last_out;

    clm_lift_encoder #(.d(D)) dut (
        .clk    (clk),
        .rst    (rst),
        .drdy_i (drdy_i),
        .P      (P),
        .pt     (pt),
        .rnd    (rnd),
        .out    (out_v),
        .busy   (busy),
        .drdy_o (drdy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: byte plus sum over set bits of P of shifted masks.
    function automatic ov_t model(pt_t p, logic [8:0] pp, rv_t r);
        ov_t res;
        for (int k = 0; k < 16; k++) begin
            logic [D+7:0] acc;
            acc = (D+8)'(p[k/4][k%4]);
            for (int j = 0; j < 9; j++) begin
                if (pp[j]) acc = acc ^ ((D+8)'(r[k]) << j);
            end
            res[k/4][k%4] = acc;
        end
        return res;
    endfunction

    function automatic logic [7:0] gf_mod(logic [D+7:0] v, logic [8:0] pp);
        logic [D+7:0] t;
        t = v;
        for (int i = D + 7; i >= 8; i--) begin
            if (t[i]) t = t ^ ((D+8)'(pp) << (i - 8));
        end
        return t[7:0];
    endfunction

    function automatic pt_t rand_pt();
        pt_t p;
        for (int k = 0; k < 16; k++) p[k/4][k%4] = 8'($urandom);
        return p;
    endfunction

    function automatic rv_t rand_rv();
        rv_t r;
        for (int k = 0; k < 16; k++) r[k] = D'($urandom);
        return r;
    endfunction

    // Caller must be positioned just after a falling edge.
    task automatic run_conv(input pt_t pt_v, input logic [8:0] p_v, input rv_t r_v,
                            input bit glitch, input pt_t pt_alt, input string name);
        ov_t exp;
        ov_t part;
        ov_t got;
        int  pulses;
        exp = model(pt_v, p_v, r_v);
        sb.push_back(exp);
        pt = pt_v;
        P = p_v;
        drdy_i = 1'b1;
        pulses = 0;
        for (int e = 0; e < 18; e++) begin
            @(posedge clk);
            @(negedge clk);
            drdy_i = glitch && (e == 4 || e == 16);
            if (glitch && e == 4) begin
                pt = pt_alt;
                P = ~p_v;
            end
            if (e <= 16) begin
                for (int k = 0; k < 16; k++)
                    part[k/4][k%4] = (k < e) ? exp[k/4][k%4] : last_out[k/4][k%4];
                checks++;
                if (out_v !== part) begin
                    errors++;
                    $display("FAIL %s progress e=%0d got %h exp %h", name, e, out_v, part);
                end
            end
            checks++;
            if (busy !== (e < 16)) begin
                errors++;
                $display("FAIL %s busy e=%0d got %b exp %b", name, e, busy, (e < 16));
            end
            if (drdy_o === 1'b1) begin
                pulses++;
                checks++;
                if (e != 16) begin
                    errors++;
                    $display("FAIL %s latency got %0d exp 17", name, e + 1);
                end
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected drdy_o got pulse exp none", name);
                end else begin
                    got = sb.pop_front();
                    checks++;
                    if (out_v !== got) begin
                        errors++;
                        $display("FAIL %s result got %h exp %h", name, out_v, got);
                    end
                end
                if (p_v[8]) begin
                    for (int k = 0; k < 16; k++) begin
                        checks++;
                        if (gf_mod(out_v[k/4][k%4], p_v) !== pt_v[k/4][k%4]) begin
                            errors++;
                            $display("FAIL %s mod_p k=%0d got %h exp %h", name, k,
                                     gf_mod(out_v[k/4][k%4], p_v), pt_v[k/4][k%4]);
                        end
                    end
                end
            end
            rnd = (e < 16) ? r_v[e] : D'($urandom);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL %s pulse_count got %0d exp 1", name, pulses);
            if (pulses == 0 && sb.size() > 0) void'(sb.pop_back());
        end
        last_out = exp;
        $display("%s: pt=%h P=%h pulses=%0d", name, pt_v, p_v, pulses);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drdy_i = 1'b1;
        P = 9'h11B;
        pt = rand_pt();
        rnd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_v !== '0 || busy !== 1'b0 || drdy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset out/busy/drdy_o got %h/%b/%b exp 0/0/0", out_v, busy, drdy_o);
        end
        rst = 1'b0;
        drdy_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe_ignored busy got %b exp 0", busy);
        end
        last_out = '0;
        $display("test_reset: out=%h busy=%b", out_v, busy);
    endtask

    task automatic test_zero_mask();
        pt_t p;
        for (int k = 0; k < 16; k++) p[k/4][k%4] = 8'(k);
        run_conv(p, 9'h11B, '0, 1'b0, '0, "zero_mask");
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (out_v[k/4][k%4] !== 15'(k)) begin
                errors++;
                $display("FAIL zero_mask k=%0d got %h exp %h", k, out_v[k/4][k%4], 15'(k));
            end
        end
    endtask

    task automatic test_pure_p();
        rv_t r;
        for (int k = 0; k < 16; k++) r[k] = 7'h01;
        run_conv('0, 9'h11B, r, 1'b0, '0, "pure_p");
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (out_v[k/4][k%4] !== 15'h011B) begin
                errors++;
                $display("FAIL pure_p k=%0d got %h exp 011b", k, out_v[k/4][k%4]);
            end
        end
    endtask

    task automatic test_mixed();
        rv_t r;
        pt_t p;
        for (int k = 0; k < 16; k++) begin
            r[k] = 7'h02;
            p[k/4][k%4] = 8'h01;
        end
        run_conv(p, 9'h11B, r, 1'b0, '0, "mixed");
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (out_v[k/4][k%4] !== 15'h0237) begin
                errors++;
                $display("FAIL mixed k=%0d got %h exp 0237", k, out_v[k/4][k%4]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            logic [8:0] pp;
            pp = 9'($urandom) | 9'h101;
            run_conv(rand_pt(), pp, rand_rv(), 1'b0, '0, "random");
        end
    endtask

    task automatic test_ignored_strobe();
        run_conv(rand_pt(), 9'h11B, rand_rv(), 1'b1, rand_pt(), "ignored_strobe");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || drdy_o !== 1'b0) begin
                errors++;
                $display("FAIL ignored_strobe idle busy/drdy_o got %b/%b exp 0/0", busy, drdy_o);
            end
        end
    endtask

    task automatic test_mid_reset();
        pt = rand_pt();
        P = 9'h11B;
        drdy_i = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            drdy_i = 1'b0;
            rnd = D'($urandom);
            if (e == 7) begin
                rst = 1'b1;
                drdy_i = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_v !== '0 || busy !== 1'b0 || drdy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset out/busy/drdy_o got %h/%b/%b exp 0/0/0", out_v, busy, drdy_o);
        end
        rst = 1'b0;
        drdy_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || drdy_o !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset quiet busy/drdy_o got %b/%b exp 0/0", busy, drdy_o);
            end
        end
        last_out = '0;
        $display("test_mid_reset: aborted conversion, out=%h", out_v);
        run_conv(rand_pt(), 9'h11B, rand_rv(), 1'b0, '0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++)
            run_conv(rand_pt(), 9'h100 | 9'($urandom), rand_rv(), 1'b0, '0, "back_to_back");
    endtask

    initial begin
        rst = 1'b1;
        drdy_i = 1'b0;
        P = '0;
        pt = '0;
        rnd = '0;
        last_out = '0;
        @(negedge clk);
        test_reset();
        test_zero_mask();
        test_pure_p();
        test_mixed();
        test_random();
        test_ignored_strobe();
        test_mid_reset();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
